// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and one-shot access sequencer for the MIPS data memory.
// Grants one word request at a time; bad addresses are acked with err and never reach memory.
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 2000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic [31:0] p0_rdata,
    output logic        p0_ack,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic [31:0] p1_rdata,
    output logic        p1_ack,
    output logic        p1_err,
    output logic        Mem_read,
    output logic        Mem_write,
    output logic [31:0] Mem_addr,
    output logic [31:0] Mem_wdata,
    input  logic [31:0] Mem_rdata,
    output logic        busy
);

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;

    state_t      state_q;
    logic        last_q;
    logic        owner_q;
    logic        we_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] rdata_q [2];
    logic [1:0]  ack_q;
    logic [1:0]  err_q;
    logic        busy_q;

    logic        winner;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        addr_ok;

    // On a tie the port that was not granted last wins; a lone requester always wins.
    always_comb begin
        winner    = p1_req & (~p0_req | ~last_q);
        sel_we    = winner ? p1_we    : p0_we;
        sel_addr  = winner ? p1_addr  : p0_addr;
        sel_wdata = winner ? p1_wdata : p0_wdata;
        addr_ok   = (sel_addr[1:0] == 2'b00) && (sel_addr <= LAST_WORD);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q[0]  <= '0;
            rdata_q[1]  <= '0;
            ack_q       <= '0;
            err_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            ack_q <= '0;
            err_q <= '0;
            case (state_q)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        owner_q <= winner;
                        last_q  <= winner;
                        we_q    <= sel_we;
                        busy_q  <= 1'b1;
                        if (addr_ok) begin
                            mem_addr_q  <= sel_addr;
                            mem_wdata_q <= sel_wdata;
                            mem_read_q  <= ~sel_we;
                            mem_write_q <= sel_we;
                            state_q     <= ISSUE;
                        end else begin
                            ack_q[winner] <= 1'b1;
                            err_q[winner] <= 1'b1;
                            state_q       <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    state_q     <= RESP;
                end
                RESP: begin
                    // Memory output is registered, so read data is only valid here.
                    if (!we_q) begin
                        rdata_q[owner_q] <= Mem_rdata;
                    end
                    ack_q[owner_q] <= 1'b1;
                    state_q        <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign p0_rdata  = rdata_q[0];
    assign p1_rdata  = rdata_q[1];
    assign p0_ack    = ack_q[0];
    assign p1_ack    = ack_q[1];
    assign p0_err    = err_q[0];
    assign p1_err    = err_q[1];
    assign Mem_read  = mem_read_q;
    assign Mem_write = mem_write_q;
    assign Mem_addr  = mem_addr_q;
    assign Mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: word memory stand-in, transaction-phase reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_dmem_arbiter;

    localparam int MEM_BYTES = 2000;
    localparam int WORDS     = MEM_BYTES / 4;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic        Mem_read, Mem_write;
    logic [31:0] Mem_addr, Mem_wdata;
    logic [31:0] Mem_rdata = 32'h0;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
        .Clk(Clk), .Rst(Rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_ack(p0_ack), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_ack(p1_ack), .p1_err(p1_err),
        .Mem_read(Mem_read), .Mem_write(Mem_write), .Mem_addr(Mem_addr),
        .Mem_wdata(Mem_wdata), .Mem_rdata(Mem_rdata), .busy(busy)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE0000 | 32'(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory stand-in: registered read, word granularity.
    logic [31:0] env_mem [WORDS];
    logic        env_init = 1'b0;
    always @(posedge Clk) begin
        if (!env_init) begin
            for (int i = 0; i < WORDS; i++) env_mem[i] <= init_word(i);
            env_init <= 1'b1;
        end else begin
            if (Mem_write && Mem_addr < MEM_BYTES) env_mem[Mem_addr[10:2]] <= Mem_wdata;
            if (Mem_read && Mem_addr < MEM_BYTES) Mem_rdata <= env_mem[Mem_addr[10:2]];
        end
    end

    // Reference model: m_age counts clocks since grant (1 strobe, 2 data, 3 ack, 0 idle).
    logic [31:0] model_mem [WORDS];
    logic        m_init  = 1'b0;
    logic        m_valid = 1'b0;
    int          m_age;
    logic        m_last, m_owner, m_we, m_legal;
    logic [31:0] m_addr, m_wdata, exp_addr, exp_wdata;
    logic [31:0] exp_rdata [2];

    always @(posedge Clk) begin : model
        int          own;
        logic        w, legal;
        logic [31:0] a, d;
        if (!m_init) begin
            for (int i = 0; i < WORDS; i++) model_mem[i] <= init_word(i);
            m_init <= 1'b1;
        end
        if (Rst) begin
            m_age <= 0; m_last <= 1'b1; m_owner <= 1'b0; m_we <= 1'b0; m_legal <= 1'b1;
            m_addr <= 0; m_wdata <= 0; exp_addr <= 0; exp_wdata <= 0;
            exp_rdata[0] <= 0; exp_rdata[1] <= 0; m_valid <= 1'b1;
        end else if (m_valid) begin
            case (m_age)
                0: if (p0_req || p1_req) begin
                    if (p0_req && p1_req) own = m_last ? 0 : 1;
                    else                  own = p1_req ? 1 : 0;
                    w     = own[0] ? p1_we    : p0_we;
                    a     = own[0] ? p1_addr  : p0_addr;
                    d     = own[0] ? p1_wdata : p0_wdata;
                    legal = (a % 4 == 0) && (a <= 32'(MEM_BYTES - 4));
                    m_owner <= own[0]; m_last <= own[0]; m_we <= w;
                    m_addr <= a; m_wdata <= d; m_legal <= legal;
                    if (legal) begin
                        exp_addr <= a; exp_wdata <= d; m_age <= 1;
                    end else begin
                        m_age <= 3;
                    end
                end
                1: begin
                    if (m_we) model_mem[m_addr[10:2]] <= m_wdata;
                    m_age <= 2;
                end
                2: begin
                    if (!m_we) exp_rdata[m_owner] <= model_mem[m_addr[10:2]];
                    m_age <= 3;
                end
                default: m_age <= 0;
            endcase
        end
    end

    // Per-cycle comparison plus strobe monitor.
    int          n_strobes = 0;
    int          strobe_cyc [$];
    logic [31:0] last_wr_addr = 0, last_wr_data = 0;
    always @(negedge Clk) begin
        if (m_valid) begin
            chk("busy",      32'(busy),      32'(m_age != 0));
            chk("mem_read",  32'(Mem_read),  32'(m_age == 1 && !m_we));
            chk("mem_write", 32'(Mem_write), 32'(m_age == 1 && m_we));
            chk("mem_addr",  Mem_addr,  exp_addr);
            chk("mem_wdata", Mem_wdata, exp_wdata);
            chk("p0_ack",    32'(p0_ack), 32'(m_age == 3 && m_owner == 1'b0));
            chk("p1_ack",    32'(p1_ack), 32'(m_age == 3 && m_owner == 1'b1));
            chk("p0_err",    32'(p0_err), 32'(m_age == 3 && m_owner == 1'b0 && !m_legal));
            chk("p1_err",    32'(p1_err), 32'(m_age == 3 && m_owner == 1'b1 && !m_legal));
            chk("p0_rdata",  p0_rdata, exp_rdata[0]);
            chk("p1_rdata",  p1_rdata, exp_rdata[1]);
        end
        if (Mem_read === 1'b1 || Mem_write === 1'b1) begin
            n_strobes++;
            strobe_cyc.push_back(cyc);
            if (Mem_write) begin
                last_wr_addr = Mem_addr;
                last_wr_data = Mem_wdata;
            end
        end
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input int p, input logic req, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d; end
        else        begin p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d; end
    endtask

    // Counts rising edges until an ack is seen; returns the acking port.
    task automatic wait_ack(output int port, output int lat);
        port = -1;
        lat  = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk);
            lat++;
            @(negedge Clk);
            if (p0_ack) begin port = 0; return; end
            if (p1_ack) begin port = 1; return; end
        end
        checks++;
        errors++;
        $display("FAIL ack_timeout: got no ack in 20 cycles, required one");
    endtask

    task automatic xfer(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int port, output logic err, output logic [31:0] rd);
        drive(p, 1'b1, we, a, d);
        wait_ack(port, lat);
        err = (p == 0) ? p0_err : p1_err;
        rd  = (p == 0) ? p0_rdata : p1_rdata;
        drive(p, 1'b0, we, a, d);
        tick();
    endtask

    initial begin
        int          lat, port, s0, n0;
        logic        err;
        logic [31:0] rd;
        Rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) tick();
        Rst = 1'b0;
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_p0_rdata", p0_rdata, 32'h0);
        chk("reset_strobes", 32'({Mem_read, Mem_write}), 32'h0);

        // Legal write then read-back on port 0.
        xfer(0, 1'b1, 32'h4, 32'h0000000A, lat, port, err, rd);
        chk("wr_port", 32'(port), 32'h0);
        chk("wr_err", 32'(err), 32'h0);
        chk("wr_latency", 32'(lat), 32'd3);
        chk("wr_mem_addr", last_wr_addr, 32'h4);
        chk("wr_mem_data", last_wr_data, 32'h0000000A);
        xfer(0, 1'b0, 32'h4, 32'h0, lat, port, err, rd);
        chk("rd_latency", 32'(lat), 32'd3);
        chk("rd_data", rd, 32'h0000000A);

        // Tie after reset: p0 first, then strict alternation.
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h8, 32'h0);
        for (int k = 0; k < 4; k++) begin
            wait_ack(port, lat);
            chk("tie_order", 32'(port), 32'(k % 2));
            chk("tie_data", (port == 1) ? p1_rdata : p0_rdata,
                (k % 2 == 0) ? 32'hC0DE0000 : 32'hC0DE0002);
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h8, 32'h0);
        tick();

        // Rejected accesses (misaligned, one past the end) and the last legal word.
        s0 = n_strobes;
        xfer(1, 1'b0, 32'h6, 32'h0, lat, port, err, rd);
        chk("misalign_err", 32'(err), 32'h1);
        chk("misalign_latency", 32'(lat), 32'd1);
        xfer(1, 1'b0, 32'h7D0, 32'h0, lat, port, err, rd);
        chk("range_err", 32'(err), 32'h1);
        chk("range_port", 32'(port), 32'h1);
        xfer(1, 1'b1, 32'hFFFFFFFC, 32'h55, lat, port, err, rd);
        chk("wrap_err", 32'(err), 32'h1);
        chk("reject_no_strobe", 32'(n_strobes - s0), 32'h0);
        xfer(1, 1'b0, 32'h7CC, 32'h0, lat, port, err, rd);
        chk("top_word_err", 32'(err), 32'h0);
        chk("top_word_data", rd, 32'hC0DE01F3);

        // Inputs changed after grant are ignored; dropping req still gets one ack.
        drive(0, 1'b1, 1'b1, 32'h10, 32'h12345678);
        tick();
        drive(0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF);
        tick();
        drive(0, 1'b0, 1'b1, 32'h20, 32'hDEADBEEF);
        wait_ack(port, lat);
        chk("late_ack_port", 32'(port), 32'h0);
        chk("late_wr_addr", last_wr_addr, 32'h10);
        chk("late_wr_data", last_wr_data, 32'h12345678);
        s0 = n_strobes;
        repeat (4) tick();
        chk("late_no_reissue", 32'(n_strobes - s0), 32'h0);
        xfer(0, 1'b0, 32'h10, 32'h0, lat, port, err, rd);
        chk("late_readback", rd, 32'h12345678);
        xfer(0, 1'b0, 32'h20, 32'h0, lat, port, err, rd);
        chk("late_untouched", rd, 32'hC0DE0008);

        // Reset during RESP drops the access; held req then completes normally.
        drive(1, 1'b1, 1'b0, 32'hC, 32'h0);
        tick();
        tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_ack", 32'({p0_ack, p1_ack}), 32'h0);
        chk("rst_mid_rdata", p1_rdata, 32'h0);
        wait_ack(port, lat);
        chk("rst_after_latency", 32'(lat), 32'd3);
        chk("rst_after_data", p1_rdata, 32'hC0DE0003);
        drive(1, 1'b0, 1'b0, 32'hC, 32'h0);
        tick();

        // Req held through the ack cycle: next access spaced a full 4 clocks.
        n0 = strobe_cyc.size();
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
        wait_ack(port, lat);
        chk("hold_first_latency", 32'(lat), 32'd3);
        wait_ack(port, lat);
        chk("hold_second_latency", 32'(lat), 32'd4);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        if (strobe_cyc.size() >= n0 + 2)
            chk("hold_strobe_gap", 32'(strobe_cyc[n0+1] - strobe_cyc[n0]), 32'd4);
        else
            chk("hold_strobe_count", 32'(strobe_cyc.size() - n0), 32'd2);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000, required finish");
        $fatal(1, "watchdog");
    end

endmodule
